// File: rtl/latency_stats_mc.sv
// latency_stats_mc: per-channel latency sum/min/max/count collector with run-control FSM
module latency_stats_mc #(
  parameter int TIME_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 2,
  parameter int IDX_WIDTH  = 5,
  parameter int SUM_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  s_valid,
  input  logic [CH_WIDTH-1:0]   s_ch,
  input  logic [TIME_WIDTH-1:0] s_tx_gray,
  input  logic [TIME_WIDTH-1:0] s_rx_gray,
  input  logic [IDX_WIDTH-1:0]  s_tx_idx,
  input  logic [IDX_WIDTH-1:0]  s_rx_idx,
  input  logic [CH_WIDTH-1:0]   rd_ch,
  output logic [SUM_WIDTH-1:0]  rd_sum,
  output logic [TIME_WIDTH-1:0] rd_min,
  output logic [TIME_WIDTH-1:0] rd_max,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  rd_sat,
  output logic [1:0]            state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic v1_q, v1_d, v2_q, v2_d;
  logic [CH_WIDTH-1:0] ch1_q, ch1_d, ch2_q, ch2_d;
  logic [TIME_WIDTH-1:0] a_q, a_d, b_q, b_d, lat_q, lat_d;
  logic [SUM_WIDTH-1:0] sum_q [NUM_CH];
  logic [SUM_WIDTH-1:0] sum_d [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [TIME_WIDTH-1:0] min_q [NUM_CH];
  logic [TIME_WIDTH-1:0] min_d [NUM_CH];
  logic [TIME_WIDTH-1:0] max_q [NUM_CH];
  logic [TIME_WIDTH-1:0] max_d [NUM_CH];
  logic sat_q [NUM_CH];
  logic sat_d [NUM_CH];
  logic [SUM_WIDTH:0] sum_x;
  logic [CNT_WIDTH:0] cnt_x;
  logic rd_ok;
  logic [SUM_WIDTH-1:0] rd_sum_q, rd_sum_d;
  logic [TIME_WIDTH-1:0] rd_min_q, rd_min_d, rd_max_q, rd_max_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic rd_sat_q, rd_sat_d;
  function automatic logic [TIME_WIDTH-1:0] g2b(input logic [TIME_WIDTH-1:0] g);
    g2b[TIME_WIDTH-1] = g[TIME_WIDTH-1];
    for (int i = TIME_WIDTH-2; i >= 0; i--) g2b[i] = g2b[i+1] ^ g[i];
  endfunction
  always_comb begin
    state_d = clear ? IDLE :
              (state_q == IDLE && start) ? RUN :
              (state_q == RUN && stop) ? DONE : state_q;
    v1_d = s_valid && state_q == RUN && !stop && !clear && 32'(s_ch) < NUM_CH;
    ch1_d = s_ch;
    a_d = g2b(s_rx_gray) + TIME_WIDTH'(s_rx_idx);
    b_d = g2b(s_tx_gray) + TIME_WIDTH'(s_tx_idx);
    v2_d = v1_q && !clear;
    ch2_d = ch1_q;
    lat_d = a_q - b_q;
  end
  // only one channel updates per cycle, so the saturating adds are shared
  always_comb begin
    sum_x = {1'b0, sum_q[ch2_q]} + (SUM_WIDTH+1)'(lat_q);
    cnt_x = {1'b0, cnt_q[ch2_q]} + (CNT_WIDTH+1)'(1);
    for (int c = 0; c < NUM_CH; c++) begin
      sum_d[c] = clear ? '0 : (v2_q && ch2_q == CH_WIDTH'(c)) ? (sum_x[SUM_WIDTH] ? '1 : sum_x[SUM_WIDTH-1:0]) : sum_q[c];
      cnt_d[c] = clear ? '0 : (v2_q && ch2_q == CH_WIDTH'(c)) ? (cnt_x[CNT_WIDTH] ? '1 : cnt_x[CNT_WIDTH-1:0]) : cnt_q[c];
      min_d[c] = clear ? '1 : (v2_q && ch2_q == CH_WIDTH'(c) && lat_q < min_q[c]) ? lat_q : min_q[c];
      max_d[c] = clear ? '0 : (v2_q && ch2_q == CH_WIDTH'(c) && lat_q > max_q[c]) ? lat_q : max_q[c];
      sat_d[c] = clear ? 1'b0 : sat_q[c] | (v2_q && ch2_q == CH_WIDTH'(c) && (sum_x[SUM_WIDTH] || cnt_x[CNT_WIDTH]));
    end
  end
  always_comb begin
    rd_ok = 32'(rd_ch) < NUM_CH;
    rd_sum_d = rd_ok ? sum_q[rd_ch] : '0;
    rd_min_d = rd_ok ? min_q[rd_ch] : '1;
    rd_max_d = rd_ok ? max_q[rd_ch] : '0;
    rd_cnt_d = rd_ok ? cnt_q[rd_ch] : '0;
    rd_sat_d = rd_ok ? sat_q[rd_ch] : 1'b0;
  end
  always_ff @(posedge clk) begin
    ch1_q <= ch1_d;
    a_q <= a_d;
    b_q <= b_d;
    ch2_q <= ch2_d;
    lat_q <= lat_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
        min_q[c] <= '1;
        max_q[c] <= '0;
        sat_q[c] <= 1'b0;
      end
      rd_sum_q <= '0;
      rd_min_q <= '1;
      rd_max_q <= '0;
      rd_cnt_q <= '0;
      rd_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      min_q <= min_d;
      max_q <= max_d;
      sat_q <= sat_d;
      rd_sum_q <= rd_sum_d;
      rd_min_q <= rd_min_d;
      rd_max_q <= rd_max_d;
      rd_cnt_q <= rd_cnt_d;
      rd_sat_q <= rd_sat_d;
    end
  end
  assign rd_sum = rd_sum_q;
  assign rd_min = rd_min_q;
  assign rd_max = rd_max_q;
  assign rd_count = rd_cnt_q;
  assign rd_sat = rd_sat_q;
  assign state = state_q;
endmodule

// File: tb/tb_latency_stats_mc.sv
// tb_latency_stats_mc: table-driven and directed checks for latency_stats_mc
module tb_latency_stats_mc;
  logic clk = 1'b0;
  logic rst_n, start, stop, clear, s_valid, s_ch_hi;
  logic [1:0] s_ch, rd_ch;
  logic [15:0] s_tx_gray, s_rx_gray;
  logic [4:0] s_tx_idx, s_rx_idx;
  logic [31:0] rd_sum;
  logic [15:0] rd_min, rd_max, rd_count;
  logic rd_sat;
  logic [1:0] state;
  logic [15:0] rd2_sum, rd2_min, rd2_max, rd2_count;
  logic rd2_sat;
  logic [1:0] state2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  latency_stats_mc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .s_valid(s_valid), .s_ch(s_ch), .s_tx_gray(s_tx_gray), .s_rx_gray(s_rx_gray),
    .s_tx_idx(s_tx_idx), .s_rx_idx(s_rx_idx), .rd_ch(rd_ch),
    .rd_sum(rd_sum), .rd_min(rd_min), .rd_max(rd_max), .rd_count(rd_count),
    .rd_sat(rd_sat), .state(state)
  );
  latency_stats_mc #(.SUM_WIDTH(16), .CH_WIDTH(3)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .s_valid(s_valid), .s_ch({s_ch_hi, s_ch}), .s_tx_gray(s_tx_gray), .s_rx_gray(s_rx_gray),
    .s_tx_idx(s_tx_idx), .s_rx_idx(s_rx_idx), .rd_ch({1'b0, rd_ch}),
    .rd_sum(rd2_sum), .rd_min(rd2_min), .rd_max(rd2_max), .rd_count(rd2_count),
    .rd_sat(rd2_sat), .state(state2)
  );
  typedef struct {
    logic [1:0] ch;
    logic [15:0] tx, rx;
    logic [4:0] txi, rxi;
    logic [15:0] lat;
  } vec_t;
  vec_t vecs [5];
  function automatic logic [15:0] gray(input logic [15:0] x);
    return x ^ (x >> 1);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [1:0] ch, input logic [15:0] tx, input logic [15:0] rx,
                      input logic [4:0] txi, input logic [4:0] rxi);
    s_valid = 1'b1;
    s_ch = ch;
    s_tx_gray = gray(tx);
    s_rx_gray = gray(rx);
    s_tx_idx = txi;
    s_rx_idx = rxi;
    tick();
    s_valid = 1'b0;
  endtask
  task automatic rd_check(input string name, input logic [1:0] ch, input logic [31:0] es,
                          input logic [15:0] emin, input logic [15:0] emax,
                          input logic [15:0] ecnt, input logic esat);
    rd_ch = ch;
    tick();
    chk({name, "_sum"}, 64'(rd_sum), 64'(es));
    chk({name, "_min"}, 64'(rd_min), 64'(emin));
    chk({name, "_max"}, 64'(rd_max), 64'(emax));
    chk({name, "_cnt"}, 64'(rd_count), 64'(ecnt));
    chk({name, "_sat"}, 64'(rd_sat), 64'(esat));
  endtask
  initial begin
    vecs[0] = '{2'd1, 16'd100, 16'd130, 5'd2, 5'd1, 16'd29};
    vecs[1] = '{2'd2, 16'hFFF0, 16'h0010, 5'd0, 5'd0, 16'h0020};
    vecs[2] = '{2'd3, 16'h0000, 16'h0000, 5'd5, 5'd0, 16'hFFFB};
    vecs[3] = '{2'd0, 16'h1234, 16'h1234, 5'd0, 5'd31, 16'h001F};
    vecs[4] = '{2'd1, 16'hFFFF, 16'h0000, 5'd0, 5'd0, 16'h0001};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; s_valid = 1'b0; s_ch_hi = 1'b0;
    s_ch = '0; rd_ch = '0; s_tx_gray = '0; s_rx_gray = '0; s_tx_idx = '0; s_rx_idx = '0;
    tick();
    tick();
    chk("reset_state", 64'(state), 64'd0);
    rd_check("reset_rd", 2'd0, 32'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_in_idle", 64'(state), 64'd0);
    pulse_start();
    chk("start_to_run", 64'(state), 64'd1);
    rd_ch = 2'd1;
    send(vecs[0].ch, vecs[0].tx, vecs[0].rx, vecs[0].txi, vecs[0].rxi);
    tick(); tick();
    chk("basic_not_early", 64'(rd_count), 64'd0);
    tick();
    chk("basic_n4_cnt", 64'(rd_count), 64'd1);
    chk("basic_n4_sum", 64'(rd_sum), 64'd29);
    rd_check("basic_other", 2'd2, 32'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pulse_clear();
      pulse_start();
      send(vecs[i].ch, vecs[i].tx, vecs[i].rx, vecs[i].txi, vecs[i].rxi);
      tick(); tick(); tick();
      rd_check($sformatf("vec%0d", i), vecs[i].ch, 32'(vecs[i].lat), vecs[i].lat, vecs[i].lat, 16'd1, 1'b0);
    end
    pulse_clear();
    pulse_start();
    send(2'd0, 16'd0, 16'd5, 5'd0, 5'd0);
    send(2'd0, 16'd0, 16'd3, 5'd0, 5'd0);
    send(2'd0, 16'd0, 16'd9, 5'd0, 5'd0);
    tick(); tick(); tick();
    rd_check("b2b", 2'd0, 32'd17, 16'd3, 16'd9, 16'd3, 1'b0);
    pulse_clear();
    send(2'd1, 16'd0, 16'd4, 5'd0, 5'd0);
    pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run", 64'(state), 64'd1);
    send(2'd1, 16'd0, 16'd7, 5'd0, 5'd0);
    stop = 1'b1;
    send(2'd1, 16'd0, 16'd50, 5'd0, 5'd0);
    stop = 1'b0;
    chk("stop_to_done", 64'(state), 64'd2);
    send(2'd1, 16'd0, 16'd60, 5'd0, 5'd0);
    pulse_start();
    chk("start_in_done", 64'(state), 64'd2);
    tick();
    rd_check("gating", 2'd1, 32'd7, 16'd7, 16'd7, 16'd1, 1'b0);
    pulse_clear();
    chk("clear_rd_lag", 64'(rd_count), 64'd1);
    chk("clear_state", 64'(state), 64'd0);
    tick();
    chk("clear_rd_cnt", 64'(rd_count), 64'd0);
    chk("clear_rd_min", 64'(rd_min), 64'hFFFF);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clear_beats_start", 64'(state), 64'd0);
    pulse_start();
    s_ch_hi = 1'b1;
    send(2'd1, 16'd0, 16'd10, 5'd0, 5'd0);
    s_ch_hi = 1'b0;
    tick(); tick(); tick();
    rd_check("oor_main", 2'd1, 32'd10, 16'd10, 16'd10, 16'd1, 1'b0);
    chk("oor_dropped_cnt", 64'(rd2_count), 64'd0);
    pulse_clear();
    pulse_start();
    send(2'd3, 16'd0, 16'hFFFF, 5'd0, 5'd0);
    send(2'd3, 16'd0, 16'd2, 5'd0, 5'd0);
    tick(); tick(); tick();
    rd_check("sat_wide", 2'd3, 32'h0001_0001, 16'd2, 16'hFFFF, 16'd2, 1'b0);
    chk("sat_sum", 64'(rd2_sum), 64'hFFFF);
    chk("sat_flag", 64'(rd2_sat), 64'd1);
    chk("sat_cnt", 64'(rd2_count), 64'd2);
    pulse_clear();
    pulse_start();
    send(2'd2, 16'd0, 16'd5, 5'd0, 5'd0);
    pulse_clear();
    chk("midclear_state", 64'(state), 64'd0);
    tick(); tick(); tick();
    rd_check("midclear", 2'd2, 32'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0);
    pulse_start();
    send(2'd2, 16'd0, 16'd5, 5'd0, 5'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_state", 64'(state), 64'd0);
    tick(); tick(); tick();
    rd_check("midreset", 2'd2, 32'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/latency_stats_mc.md
# latency_stats_mc

Multi-channel latency statistics collector for the NoC measurement path. It accepts Gray-coded TX/RX time stamps tagged with a channel number, converts both to binary, and applies per-endpoint index compensation. It computes the modulo-2^TIME_WIDTH latency and keeps per-channel sum, min, max and sample count. A run-control FSM gates accumulation, and a registered read port exposes one channel's statistics at a time.

## Interface
Parameters:
- TIME_WIDTH, 16, width of time stamps and of every latency value
- NUM_CH, 4, number of statistics channels (≥1)
- CH_WIDTH, 2, channel-number width; must satisfy 2^CH_WIDTH ≥ NUM_CH
- IDX_WIDTH, 5, width of the TX/RX index compensation offsets
- SUM_WIDTH, 32, width of per-channel latency sum (≥ TIME_WIDTH)
- CNT_WIDTH, 16, width of per-channel sample counter

Ports:
- clk  in  1  single clock for the whole block
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  pulse; IDLE→RUN
- stop  in  1  pulse; RUN→DONE (receive-finish)
- clear  in  1  pulse; zero all statistics, FSM→IDLE
- s_valid  in  1  sample present this cycle
- s_ch  in  CH_WIDTH  sample channel
- s_tx_gray  in  TIME_WIDTH  Gray-coded send time stamp
- s_rx_gray  in  TIME_WIDTH  Gray-coded receive time stamp
- s_tx_idx  in  IDX_WIDTH  TX-side compensation offset
- s_rx_idx  in  IDX_WIDTH  RX-side compensation offset
- rd_ch  in  CH_WIDTH  channel selected for readout
- rd_sum  out  SUM_WIDTH  sum of latencies of rd_ch
- rd_min  out  TIME_WIDTH  minimum latency of rd_ch
- rd_max  out  TIME_WIDTH  maximum latency of rd_ch
- rd_count  out  CNT_WIDTH  accepted-sample count of rd_ch
- rd_sat  out  1  sum or count of rd_ch has saturated
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 DONE

## Operation
- FSM: IDLE –start→ RUN –stop→ DONE –clear→ IDLE. clear from any state → IDLE. start is ignored in RUN/DONE. stop is ignored in IDLE/DONE. If clear is asserted in the same cycle as start or stop, clear wins.
- Sample acceptance: a sample enters the pipeline only if s_valid=1, state==RUN, stop=0 and clear=0 in its input cycle, and s_ch<NUM_CH. Out-of-range channels are dropped silently.
- S1 (register): Gray→binary for both stamps, with bin[MSB]=g[MSB] and bin[i]=bin[i+1]^g[i]. Computes a=rx_bin+rx_idx and b=tx_bin+tx_idx, with offsets zero-extended and results truncated to TIME_WIDTH.
- S2 (register): lat = (a − b) mod 2^TIME_WIDTH, i.e. when a<b, lat = a + 2^TIME_WIDTH − b.
- S3 (update, per-channel registers): on the target channel, apply all of the following:
  - sum += lat, saturating at all-ones;
  - count += 1, saturating at all-ones;
  - min = min(min, lat);
  - max = max(max, lat);
  - sat is set sticky if sum or count saturates.
- Read-modify-write completes in S3 in one cycle, so back-to-back samples on the same channel are each applied exactly once.
- Samples already in S1/S2 when stop arrives still complete. clear flushes the pipeline valids, so in-flight samples are discarded.
- Statistics hold their values in DONE and IDLE until cleared.
- Per-channel clear values: sum=0, count=0, max=0, min=all-ones, sat=0.

## Timing
- Reset (rst_n=0 at a clk edge) has these effects:
  - state=IDLE;
  - all channels at their clear values;
  - pipeline valids=0;
  - rd_sum=0, rd_min=all-ones, rd_max=0, rd_count=0, rd_sat=0.
- Reset applied mid-run takes effect at that edge, and in-flight samples are lost.
- Sample latency: input at edge N lands in channel statistics at edge N+3.
- Read latency: rd_* reflects rd_ch's statistics as of edge K, registered at edge K+1. A sample input at N is therefore visible on rd_* after edge N+4.
- Full throughput is one sample per cycle, with no backpressure.
- clear at edge K: the statistics show clear values after K, and rd_* shows them after K+1.

## Test plan
- Basic: reset, then start, then one sample ch1 with tx=Gray(100), rx=Gray(130), tx_idx=2, rx_idx=1. Expect ch1 sum=29, min=29, max=29, count=1 at N+3, and rd_* valid at N+4. Other channels remain at clear values.
- Wrap: tx=Gray(0xFFF0), rx=Gray(0x0010), offsets 0. Expect lat=0x0020.
- Back-to-back same channel: latencies 5, 3, 9 on ch0 in consecutive cycles. Expect sum=17, min=3, max=9, count=3.
- Gating: samples in IDLE or DONE, in the stop cycle, and with s_ch≥NUM_CH are all ignored. Samples entered one cycle before stop are counted.
- Saturation: with SUM_WIDTH=TIME_WIDTH=16, feed 0xFFFF then 0x0002. Expect sum=0xFFFF and rd_sat=1.
- Clear and reset mid-run: clear on the cycle after a sample input drops that sample and returns state=0. Applying rst_n=0 in RUN gives the same result.
